jtag_shift_master: RTL and testbench
====================================

Name: jtag_shift_master

Overview:
- Synthesizable JTAG initiator. It drives the TCK/TMS/TDI/TRST_N wires that the testharness TAP inputs receive, and samples TDO.
- Replaces the DPI JTAG driver when JTAG_DPI=0, so firmware load and debug-module access work in any simulator and on FPGA.
- Accepts scan commands on a valid/ready port, walks the TAP state machine and returns captured TDO bits on a valid/ready response port.

Parameters:
- MAX_LEN, 32: maximum scan length in bits; also the width of the data paths.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len_i.
- CLK_DIV, 4: clk_i cycles per TCK half-period. Legal range ≥1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_op_i  in  2  0=TAP_RESET, 1=IR_SCAN, 2=DR_SCAN, 3=IDLE
- cmd_len_i  in  LEN_W  scan bits, or RTI TCK cycles for IDLE
- cmd_data_i  in  MAX_LEN  TDI bits, LSB shifted first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_data_o  out  MAX_LEN  captured TDO, LSB = first bit, right-aligned
- busy_o  out  1  high from command accept until response handshake
- jtag_tck_o  out  1  TCK
- jtag_trst_no  out  1  TAP reset, active low
- jtag_tms_o  out  1  TMS
- jtag_tdi_o  out  1  TDI
- jtag_tdo_i  in  1  TDO from TAP

Behaviour:
- Reset values: cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0, jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0, jtag_trst_no=0.
- Post-reset sequence: trst_no stays 0 for 4 TCK periods, then rises to 1.
- After the post-reset sequence the FSM enters IDLE and cmd_ready_o=1.
- TCK timing:
  - Half-period counter 0..CLK_DIV-1 with wrap, so one TCK period = 2*CLK_DIV clk cycles.
  - TCK toggles only while the FSM is not in IDLE or RESP; it is parked low otherwise.
  - TMS/TDI update in the same clk as the TCK falling edge.
  - TDO is sampled in the same clk as the TCK rising edge.
- FSM states: RST_TRST, IDLE, PRE, SHIFT, POST, RUN, RESP.
  - IDLE: cmd_ready_o=1. On handshake, latch op/len/data, drop ready, go to PRE.
  - PRE: emits a TMS prefix, one bit per TCK.
    - TAP_RESET: 1,1,1,1,1,0, then RESP. Ends in Run-Test/Idle.
    - DR_SCAN: 1,0,0, which reaches Shift-DR.
    - IR_SCAN: 1,1,0,0, which reaches Shift-IR.
    - IDLE op: no prefix; go to RUN.
  - SHIFT: len TCK periods. TDI = data[i], TMS=0 except the last bit, which has TMS=1 (Exit1). The TDO sampled on the rising edge of bit i goes to capture[i].
  - POST: TMS 1 (Update), then 0 (Run-Test/Idle), then RESP.
  - RUN: len TCK periods with TMS=0, then RESP. len=0 goes straight to RESP.
  - RESP: rsp_valid_o=1, rsp_data_o=capture; bits ≥ len are 0. Hold until rsp_ready_i, then IDLE.
- Length rules:
  - Scan with len=0 is treated as len=1.
  - len>MAX_LEN is clamped to MAX_LEN.
  - TAP_RESET ignores len and data.
- Response data:
  - rsp_data_o is stable while rsp_valid_o=1.
  - TAP_RESET and IDLE ops return rsp_data_o=0.
- cmd_valid_i while busy is ignored, because ready=0. Commands are not queued.
- The block always returns the TAP to Run-Test/Idle between commands.
- Reset mid-operation: all state aborts immediately to reset values; the in-flight response is lost.
- The RST_TRST sequence is rerun after every reset.

Decomposition:
- Package jtag_master_pkg holds:
  - enum jtag_op_e (TAP_RESET, IR_SCAN, DR_SCAN, IDLE_OP)
  - FSM state enum
  - TMS prefix constants: RESET 6'b011111 (LSB first), DR 3'b001, IR 4'b0011
- One sub-module, jtag_tck_gen: half-period counter plus TCK register. It outputs one-cycle pulses tck_rise_o and tck_fall_o, enabled by run_i.

Test Plan:
- Post-reset: reset released → trst_no=0 for 8*CLK_DIV clk cycles, then 1; cmd_ready_o=1; tck_o stays 0.
- TAP_RESET cmd → TMS on 6 rising edges = 1,1,1,1,1,0. A TAP model reports Run-Test/Idle. rsp_data_o=0.
- DR_SCAN len=32, TAP model with IDCODE 0x1000_5DEE selected → rsp_data_o=0x1000_5DEE. Exactly 32 shift TCKs, Exit1 on bit 32, TAP ends in Run-Test/Idle.
- IR_SCAN len=5 data=5'h11 → TAP IR=0x11 after Update-IR. rsp_data_o[4:0]=5'b00001 (capture pattern), upper bits 0.
- Backpressure: rsp_ready_i held 0 for 20 cycles → rsp_valid_o and data stable; busy_o=1. A second cmd_valid_i is not accepted until the response handshake.
- Reset asserted mid-DR_SCAN (bit 10) → next clk: outputs at reset values, rsp_valid_o stays 0, trst sequence rerun.

Source files
------------

// File: rtl/jtag_master_pkg.sv
// Shared types and constants for the synthesizable JTAG shift master.
// TMS prefix words are stored LSB first: bit 0 is driven on the first TCK.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        TAP_RESET = 2'd0,
        IR_SCAN   = 2'd1,
        DR_SCAN   = 2'd2,
        IDLE_OP   = 2'd3
    } jtag_op_e;

    typedef logic [2:0] jtag_state_t;

    localparam jtag_state_t ST_RST_TRST = 3'd0;
    localparam jtag_state_t ST_IDLE     = 3'd1;
    localparam jtag_state_t ST_PRE      = 3'd2;
    localparam jtag_state_t ST_SHIFT    = 3'd3;
    localparam jtag_state_t ST_POST     = 3'd4;
    localparam jtag_state_t ST_RUN      = 3'd5;
    localparam jtag_state_t ST_RESP     = 3'd6;

    localparam logic [5:0] TMS_RESET = 6'b011111;
    localparam logic [2:0] TMS_DR    = 3'b001;
    localparam logic [3:0] TMS_IR    = 4'b0011;

    localparam int TRST_TCKS = 4;

endpackage

// File: rtl/jtag_shift_master_tck_gen.sv
// TCK generator: half-period counter plus TCK register, parked low when idle.
// The rise/fall strobes mark the clk in which the TCK register changes.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tck_o,
    output logic tck_rise_o,
    output logic tck_fall_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tck;
    logic             w_wrap;

    assign w_wrap     = run_i && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign tck_rise_o = w_wrap && !r_tck;
    assign tck_fall_o = w_wrap && r_tck;
    assign tck_o      = r_tck;

    // Half-period counter; stopping the clock also parks TCK low
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= {CNT_W{1'b0}};
            r_tck <= 1'b0;
        end else if (!run_i) begin
            r_cnt <= {CNT_W{1'b0}};
            r_tck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= {CNT_W{1'b0}};
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_shift_master.sv
// JTAG initiator: takes scan commands, walks the TAP through the needed
// states on TMS/TDI and returns the TDO bits captured during the shift.
module jtag_shift_master
    import jtag_master_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CLK_DIV = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               busy_o,
    output logic               jtag_tck_o,
    output logic               jtag_trst_no,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    input  logic               jtag_tdo_i
);

    jtag_state_t        r_state;
    jtag_op_e           r_op;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic [5:0]         r_pat;
    logic [2:0]         r_pre_last;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic               r_busy;
    logic               r_trst_n;
    logic               r_tms;
    logic               r_tdi;

    logic               w_run;
    logic               w_rise;
    logic               w_fall;
    logic               w_last;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_scan_len;
    logic [LEN_W-1:0]   w_shamt;
    logic [MAX_LEN-1:0] w_rsp_aligned;
    logic [5:0]         w_pat;
    logic [2:0]         w_pre_last;

    assign w_run  = (r_state != ST_IDLE) && (r_state != ST_RESP);
    assign w_last = (r_idx == (r_len - LEN_W'(1)));

    // Captured bits enter at the MSB, so the first bit lands at MAX_LEN-len
    assign w_shamt       = LEN_W'(MAX_LEN) - r_len;
    assign w_rsp_aligned = r_cap >> w_shamt;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .run_i      (w_run),
        .tck_o      (jtag_tck_o),
        .tck_rise_o (w_rise),
        .tck_fall_o (w_fall)
    );

    // Command length after clamping; scans shift at least one bit
    always_comb begin
        w_len_clamp = cmd_len_i;
        w_scan_len  = cmd_len_i;
        if (cmd_len_i > LEN_W'(MAX_LEN)) begin
            w_len_clamp = LEN_W'(MAX_LEN);
        end else begin
            w_len_clamp = cmd_len_i;
        end
        if (w_len_clamp == {LEN_W{1'b0}}) begin
            w_scan_len = LEN_W'(1);
        end else begin
            w_scan_len = w_len_clamp;
        end
    end

    // TMS prefix for the incoming op
    always_comb begin
        w_pat      = 6'b000000;
        w_pre_last = 3'd0;
        case (jtag_op_e'(cmd_op_i))
            TAP_RESET: begin
                w_pat      = TMS_RESET;
                w_pre_last = 3'd5;
            end
            IR_SCAN: begin
                w_pat      = {2'b00, TMS_IR};
                w_pre_last = 3'd3;
            end
            DR_SCAN: begin
                w_pat      = {3'b000, TMS_DR};
                w_pre_last = 3'd2;
            end
            default: begin
                w_pat      = 6'b000000;
                w_pre_last = 3'd0;
            end
        endcase
    end

    // Command FSM: TMS/TDI change on TCK fall, TDO is taken on TCK rise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RST_TRST;
            r_op        <= TAP_RESET;
            r_len       <= {LEN_W{1'b0}};
            r_idx       <= {LEN_W{1'b0}};
            r_data      <= {MAX_LEN{1'b0}};
            r_cap       <= {MAX_LEN{1'b0}};
            r_rsp_data  <= {MAX_LEN{1'b0}};
            r_pat       <= 6'b000000;
            r_pre_last  <= 3'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_trst_n    <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
        end else begin
            case (r_state)
                ST_RST_TRST: begin
                    if (w_fall) begin
                        if (r_idx == LEN_W'(TRST_TCKS - 1)) begin
                            r_trst_n    <= 1'b1;
                            r_cmd_ready <= 1'b1;
                            r_idx       <= {LEN_W{1'b0}};
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx <= r_idx + LEN_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= jtag_op_e'(cmd_op_i);
                        r_data      <= cmd_data_i;
                        r_cap       <= {MAX_LEN{1'b0}};
                        r_idx       <= {LEN_W{1'b0}};
                        r_pat       <= w_pat;
                        r_pre_last  <= w_pre_last;
                        r_tdi       <= 1'b0;
                        case (jtag_op_e'(cmd_op_i))
                            TAP_RESET: begin
                                r_len   <= {LEN_W{1'b0}};
                                r_tms   <= w_pat[0];
                                r_state <= ST_PRE;
                            end
                            IR_SCAN, DR_SCAN: begin
                                r_len   <= w_scan_len;
                                r_tms   <= w_pat[0];
                                r_state <= ST_PRE;
                            end
                            default: begin
                                r_len <= w_len_clamp;
                                r_tms <= 1'b0;
                                if (w_len_clamp == {LEN_W{1'b0}}) begin
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= {MAX_LEN{1'b0}};
                                    r_state     <= ST_RESP;
                                end else begin
                                    r_state <= ST_RUN;
                                end
                            end
                        endcase
                    end
                end
                ST_PRE: begin
                    if (w_fall) begin
                        if (r_idx == LEN_W'(r_pre_last)) begin
                            r_idx <= {LEN_W{1'b0}};
                            if (r_op == TAP_RESET) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= {MAX_LEN{1'b0}};
                                r_state     <= ST_RESP;
                            end else begin
                                r_tms   <= (r_len == LEN_W'(1));
                                r_tdi   <= r_data[0];
                                r_state <= ST_SHIFT;
                            end
                        end else begin
                            r_idx <= r_idx + LEN_W'(1);
                            r_pat <= r_pat >> 1;
                            r_tms <= r_pat[1];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_cap <= {jtag_tdo_i, r_cap[MAX_LEN-1:1]};
                    end
                    if (w_fall) begin
                        if (w_last) begin
                            r_idx   <= {LEN_W{1'b0}};
                            r_tms   <= 1'b1;
                            r_tdi   <= 1'b0;
                            r_state <= ST_POST;
                        end else begin
                            r_idx  <= r_idx + LEN_W'(1);
                            r_data <= r_data >> 1;
                            r_tdi  <= r_data[1];
                            r_tms  <= ((r_idx + LEN_W'(2)) == r_len);
                        end
                    end
                end
                ST_POST: begin
                    if (w_fall) begin
                        if (r_idx == {LEN_W{1'b0}}) begin
                            r_idx <= LEN_W'(1);
                            r_tms <= 1'b0;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_rsp_aligned;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_fall) begin
                        if (w_last) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= {MAX_LEN{1'b0}};
                            r_state     <= ST_RESP;
                        end else begin
                            r_idx <= r_idx + LEN_W'(1);
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_RST_TRST;
                    r_idx       <= {LEN_W{1'b0}};
                    r_cmd_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_trst_n    <= 1'b0;
                    r_tms       <= 1'b1;
                    r_tdi       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o  = r_cmd_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_data_o   = r_rsp_data;
    assign busy_o       = r_busy;
    assign jtag_trst_no = r_trst_n;
    assign jtag_tms_o   = r_tms;
    assign jtag_tdi_o   = r_tdi;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Bench for jtag_shift_master: a behavioural TAP (IDCODE, 5-bit IR, bypass)
// answers the DUT, and expected responses flow through a scoreboard queue.
module tb_jtag_shift_master;
    import jtag_master_pkg::*;

    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;
    localparam int CLK_DIV = 4;
    localparam logic [31:0] IDCODE = 32'h1000_5DEE;

    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;
    logic [31:0]      cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             busy;
    logic             tck;
    logic             trst_n;
    logic             tms;
    logic             tdi;
    logic             tdo = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    jtag_shift_master #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_len_i    (cmd_len),
        .cmd_data_i   (cmd_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy),
        .jtag_tck_o   (tck),
        .jtag_trst_no (trst_n),
        .jtag_tms_o   (tms),
        .jtag_tdi_o   (tdi),
        .jtag_tdo_i   (tdo)
    );

    // ---------------- behavioural TAP ----------------
    int          tap_st    = TLR;
    logic [4:0]  tap_ir    = 5'h01;
    logic [4:0]  tap_ir_sr = 5'h00;
    logic [31:0] tap_dr_sr = 32'h0;
    logic        tap_byp   = 1'b0;
    int          rise_cnt  = 0;
    int          shdr_cnt  = 0;
    logic [7:0]  tms_hist  = 8'h00;

    function automatic int tap_next(input int s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PADR;
            PADR:    return m ? EX2DR : PADR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PAIR;
            PAIR:    return m ? EX2IR : PAIR;
            EX2IR:   return m ? UPIR  : SHIR;
            UPIR:    return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_st <= TLR;
            tap_ir <= 5'h01;
        end else begin
            rise_cnt <= rise_cnt + 1;
            tms_hist <= {tms_hist[6:0], tms};
            case (tap_st)
                TLR:   tap_ir <= 5'h01;
                CAPDR: begin tap_dr_sr <= IDCODE; tap_byp <= 1'b0; end
                SHDR:  begin
                    shdr_cnt  <= shdr_cnt + 1;
                    tap_dr_sr <= {tdi, tap_dr_sr[31:1]};
                    tap_byp   <= tdi;
                end
                CAPIR: tap_ir_sr <= 5'b00001;
                SHIR:  tap_ir_sr <= {tdi, tap_ir_sr[4:1]};
                UPIR:  tap_ir <= tap_ir_sr;
                default: ;
            endcase
            tap_st <= tap_next(tap_st, tms);
        end
    end

    always @(negedge tck) begin
        if (tap_st == SHDR)      tdo <= (tap_ir == 5'h01) ? tap_dr_sr[0] : tap_byp;
        else if (tap_st == SHIR) tdo <= tap_ir_sr[0];
        else                     tdo <= 1'b0;
    end

    // ---------------- stimulus / scoreboard ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                            input logic [31:0] data, input logic [31:0] exp);
        bit done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        for (int i = 0; i < 400 && !done; i++) begin
            if (cmd_ready) begin
                exp_q.push_back(exp);
                done = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL cmd_accept: cmd_ready=0 after 400 cycles, required 1");
        end
    endtask

    task automatic get_rsp(input string name);
        bit          done = 1'b0;
        logic [31:0] exp;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL %s: unexpected response %h, none required", name, rsp_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (rsp_data !== exp) begin
                        n_errors++;
                        $display("FAIL %s: rsp_data=%h required %h", name, rsp_data, exp);
                    end
                end
                rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: rsp_valid timeout, got 0 required 1", name);
        end
    endtask

    task automatic test_reset();
        int zeros = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, busy, tck, tms, tdi, trst_n} !== 7'b0000100 || rsp_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_values: rdy/vld/busy/tck/tms/tdi/trst=%b data=%h required 0000100 0",
                     {cmd_ready, rsp_valid, busy, tck, tms, tdi, trst_n}, rsp_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (trst_n !== 1'b0) break;
            zeros++;
            @(negedge clk);
        end
        n_checks++;
        if (zeros != 8 * CLK_DIV) begin
            n_errors++;
            $display("FAIL trst_len: trst_n low for %0d clks, required %0d", zeros, 8 * CLK_DIV);
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || trst_n !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_trst: ready=%b trst_n=%b required 1 1", cmd_ready, trst_n);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (tck !== 1'b0) begin
                n_errors++;
                $display("FAIL tck_parked: tck=%b required 0", tck);
            end
        end
    endtask

    task automatic test_tap_reset();
        int r0 = rise_cnt;
        send_cmd(TAP_RESET, 6'd0, 32'hFFFF_FFFF, 32'h0);
        get_rsp("tap_reset_rsp");
        n_checks++;
        if (rise_cnt - r0 != 6 || tms_hist[5:0] !== 6'b111110) begin
            n_errors++;
            $display("FAIL tap_reset_tms: rises=%0d tms=%b required 6 111110", rise_cnt - r0, tms_hist[5:0]);
        end
        n_checks++;
        if (tap_st != RTI) begin
            n_errors++;
            $display("FAIL tap_reset_state: tap state %0d required %0d", tap_st, RTI);
        end
    endtask

    task automatic test_idcode();
        int s0 = shdr_cnt;
        int r0 = rise_cnt;
        send_cmd(DR_SCAN, 6'd32, 32'h0, IDCODE);
        get_rsp("idcode_rsp");
        n_checks++;
        if (shdr_cnt - s0 != 32 || rise_cnt - r0 != 37 || tap_st != RTI) begin
            n_errors++;
            $display("FAIL idcode_walk: shifts=%0d rises=%0d state=%0d required 32 37 %0d",
                     shdr_cnt - s0, rise_cnt - r0, tap_st, RTI);
        end
    endtask

    task automatic test_ir_scan();
        send_cmd(IR_SCAN, 6'd5, 32'h0000_0011, 32'h0000_0001);
        get_rsp("ir_scan_rsp");
        n_checks++;
        if (tap_ir !== 5'h11 || tap_st != RTI) begin
            n_errors++;
            $display("FAIL ir_update: ir=%h state=%0d required 11 %0d", tap_ir, tap_st, RTI);
        end
    endtask

    task automatic test_length_rules();
        int lens[5] = '{8, 0, 40, 17, 1};
        for (int k = 0; k < 5; k++) begin
            int          eff;
            int          s0;
            logic [31:0] data;
            logic [31:0] mask;
            data = $urandom;
            eff  = (lens[k] == 0) ? 1 : ((lens[k] > 32) ? 32 : lens[k]);
            mask = (eff >= 32) ? 32'hFFFF_FFFF : ((32'h1 << eff) - 32'h1);
            s0   = shdr_cnt;
            send_cmd(DR_SCAN, LEN_W'(lens[k]), data, (data << 1) & mask);
            get_rsp("bypass_rsp");
            n_checks++;
            if (shdr_cnt - s0 != eff || tap_st != RTI) begin
                n_errors++;
                $display("FAIL bypass_len: len=%0d shifts=%0d state=%0d required %0d %0d",
                         lens[k], shdr_cnt - s0, tap_st, eff, RTI);
            end
        end
    endtask

    task automatic test_run_idle();
        int r0 = rise_cnt;
        send_cmd(IDLE_OP, 6'd3, 32'hDEAD_BEEF, 32'h0);
        get_rsp("idle3_rsp");
        n_checks++;
        if (rise_cnt - r0 != 3 || tms_hist[2:0] !== 3'b000 || tap_st != RTI) begin
            n_errors++;
            $display("FAIL idle3: rises=%0d tms=%b state=%0d required 3 000 %0d",
                     rise_cnt - r0, tms_hist[2:0], tap_st, RTI);
        end
        r0 = rise_cnt;
        send_cmd(IDLE_OP, 6'd0, 32'h1234_5678, 32'h0);
        get_rsp("idle0_rsp");
        n_checks++;
        if (rise_cnt - r0 != 0) begin
            n_errors++;
            $display("FAIL idle0: rises=%0d required 0", rise_cnt - r0);
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        send_cmd(DR_SCAN, 6'd8, 32'h0000_005A, 32'h0000_00B4);
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL bp_wait: rsp_valid=0 required 1");
        end
        cmd_valid = 1'b1; cmd_op = IDLE_OP; cmd_len = 6'd2; cmd_data = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== 32'h0000_00B4) begin
                n_errors++;
                $display("FAIL bp_hold: vld=%b busy=%b rdy=%b data=%h required 1 1 0 000000b4",
                         rsp_valid, busy, cmd_ready, rsp_data);
            end
        end
        cmd_valid = 1'b0;
        get_rsp("bp_rsp");
        n_checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release: busy=%b rdy=%b vld=%b required 0 1 0", busy, cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int s0 = shdr_cnt;
        bit hit = 1'b0;
        bit vld_seen = 1'b0;
        send_cmd(DR_SCAN, 6'd32, $urandom, 32'h0);
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = (shdr_cnt - s0 >= 10);
        end
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL mid_wait: shifts=%0d required 10", shdr_cnt - s0);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, busy, tck, tms, tdi, trst_n} !== 7'b0000100 || rsp_data !== 32'h0) begin
            n_errors++;
            $display("FAIL mid_reset_values: rdy/vld/busy/tck/tms/tdi/trst=%b data=%h required 0000100 0",
                     {cmd_ready, rsp_valid, busy, tck, tms, tdi, trst_n}, rsp_data);
        end
        exp_q.delete();
        test_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) vld_seen = 1'b1;
        end
        n_checks++;
        if (vld_seen) begin
            n_errors++;
            $display("FAIL lost_rsp: rsp_valid=1 after reset, required 0");
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 6'd0;
        cmd_data = 32'h0; rsp_ready = 1'b0;
        test_reset();
        test_tap_reset();
        test_idcode();
        test_ir_scan();
        test_length_rules();
        test_run_idle();
        test_backpressure();
        test_reset_mid_scan();
        test_tap_reset();
        test_idcode();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
